// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and default constants for the SD SPI arbiter
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_PHYS = 2'd0,
        ST_VIRT = 2'd1,
        ST_PEND = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_ACT_TIMEOUT  = 1000000;
    localparam int unsigned DEF_DRAIN_CYCLES = 16;
    localparam int unsigned DEF_RESET_PULSE  = 64;

endpackage

// File: rtl/sd_act_timer.sv
// rtl/sd_act_timer.sv - edge detector feeding a saturating idle counter; act is high until it saturates
module sd_act_timer #(
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned W       = 2
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [W-1:0] i_data,
    output logic         o_act
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT);

    logic [W-1:0]  r_prev;
    logic [CW-1:0] r_cnt;

    // Any bit changing versus the previous cycle restarts the idle count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_prev <= i_data;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_data;
            if (i_data != r_prev)
                r_cnt <= '0;
            else if (r_cnt != C_MAX)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_act = (r_cnt < C_MAX);

endmodule

// File: rtl/sd_spi_arbiter.sv
// rtl/sd_spi_arbiter.sv - shares one SPI master between the physical and virtual SD card, switching only while idle
module sd_spi_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned ACT_TIMEOUT  = DEF_ACT_TIMEOUT,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned RESET_PULSE  = DEF_RESET_PULSE
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic img_mounted,
    input  logic img_present,
    input  logic reset_after_mount,
    input  logic spi_sck,
    input  logic spi_mosi,
    input  logic spi_ss_n,
    output logic spi_miso,
    output logic phys_sck,
    output logic phys_mosi,
    output logic phys_cs_n,
    input  logic phys_miso,
    output logic vsd_sck,
    output logic vsd_mosi,
    output logic vsd_ss_n,
    input  logic vsd_miso,
    output logic sel_virtual,
    output logic led_user,
    output logic led_disk,
    output logic mount_reset
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned RW = $clog2(RESET_PULSE + 1);
    localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [RW-1:0] C_PULSE      = RW'(RESET_PULSE);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic          r_target;
    logic          r_sel_virtual;
    logic          w_target_next;
    logic          w_sel_next;
    logic [DW-1:0] r_drain;
    logic [DW-1:0] w_drain_next;
    logic [RW-1:0] r_rst_cnt;
    logic          r_led_user;
    logic          r_led_disk;
    logic          w_miso;
    logic          w_act;

    assign w_target_next = img_mounted ? img_present : r_target;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= ST_PHYS;
            r_target      <= 1'b0;
            r_sel_virtual <= 1'b0;
            r_drain       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_target      <= w_target_next;
            r_sel_virtual <= w_sel_next;
            r_drain       <= w_drain_next;
        end
    end

    // r_sel_virtual keeps naming the pre-pend owner until the drain completes.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel_virtual;
        w_drain_next = '0;
        case (r_state)
            ST_PHYS, ST_VIRT: begin
                if (w_target_next != r_sel_virtual)
                    w_state_next = ST_PEND;
            end
            ST_PEND: begin
                if (img_mounted && (img_present == r_sel_virtual)) begin
                    w_state_next = r_sel_virtual ? ST_VIRT : ST_PHYS;
                end else if (spi_ss_n) begin
                    if (r_drain == C_DRAIN_LAST) begin
                        w_state_next = w_target_next ? ST_VIRT : ST_PHYS;
                        w_sel_next   = w_target_next;
                    end else begin
                        w_drain_next = r_drain + DW'(1);
                    end
                end
            end
            default: w_state_next = ST_PHYS;
        endcase
    end

    // Everything parked while pending, so the owner flip never shows a glitch.
    always_comb begin
        phys_cs_n = 1'b1;
        phys_sck  = 1'b0;
        phys_mosi = 1'b0;
        vsd_ss_n  = 1'b1;
        vsd_sck   = 1'b0;
        vsd_mosi  = 1'b0;
        w_miso    = 1'b1;
        case (r_state)
            ST_PHYS: begin
                phys_cs_n = spi_ss_n;
                phys_sck  = spi_sck;
                phys_mosi = spi_mosi;
                w_miso    = phys_miso;
            end
            ST_VIRT: begin
                vsd_ss_n = spi_ss_n;
                vsd_sck  = spi_sck;
                vsd_mosi = spi_mosi;
                w_miso   = vsd_miso;
            end
            default: ;
        endcase
    end

    assign spi_miso = w_miso;

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_rst_cnt <= '0;
        else if (img_mounted && reset_after_mount)
            r_rst_cnt <= C_PULSE;
        else if (r_rst_cnt != '0)
            r_rst_cnt <= r_rst_cnt - RW'(1);
    end

    assign mount_reset = (r_rst_cnt != '0);

    sd_act_timer #(
        .TIMEOUT (ACT_TIMEOUT),
        .W       (2)
    ) u_act_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_data  ({spi_mosi, w_miso}),
        .o_act   (w_act)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_led_user <= 1'b0;
            r_led_disk <= 1'b0;
        end else begin
            r_led_user <= r_sel_virtual & w_act;
            r_led_disk <= ~r_sel_virtual & w_act;
        end
    end

    assign sel_virtual = r_sel_virtual;
    assign led_user    = r_led_user;
    assign led_disk    = r_led_disk;

endmodule
